// File: rtl/io_reg_bank.sv
// io_reg_bank: address-decoded bank of output registers written from the
// processor OUT_PORT. The bank has an optional staged (shadow) load that is
// applied atomically on commit, a registered read-back path, and a per-register
// update pulse.
module io_reg_bank #(
    parameter int unsigned       WIDTH     = 8,
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       AW        = 16,
    parameter int unsigned       BASE      = 0,
    parameter int unsigned       SHADOW    = 0,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          port_id,
    input  logic                   write_strobe,
    input  logic                   read_strobe,
    input  logic [WIDTH-1:0]       out_port,
    input  logic                   commit,
    output logic [DEPTH*WIDTH-1:0] q,
    output logic [DEPTH-1:0]       upd,
    output logic [DEPTH-1:0]       pending,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid
);

    localparam bit SHADOW_EN = (SHADOW != 0);

    // Reject register windows that do not fit in the port address space.
    if ((64'(BASE) + 64'(DEPTH)) > (64'd1 << AW)) begin : g_bad_window
        $error("io_reg_bank: BASE+DEPTH exceeds 2^AW");
    end
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("io_reg_bank: DEPTH must be 1..16");
    end

    logic [DEPTH-1:0][WIDTH-1:0] q_r;
    logic [DEPTH-1:0][WIDTH-1:0] stage_r;
    logic [DEPTH-1:0]            pend_r;
    logic [DEPTH-1:0]            upd_r;
    logic [WIDTH-1:0]            rdata_r;
    logic                        rvalid_r;

    logic [DEPTH-1:0]            sel_c;
    logic [DEPTH-1:0]            wr_c;
    logic [DEPTH-1:0]            ld_c;
    logic                        rd_hit_c;
    logic [WIDTH-1:0]            rd_mux_c;

    // One-hot window decode. The comparison is AW+1 bits wide, so BASE+i never wraps.
    always_comb begin
        sel_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_c[i] = ({1'b0, port_id} == (AW+1)'(BASE + i));
        end
    end

    // Write and load enables, plus the read-back mux of the active values.
    always_comb begin
        wr_c     = sel_c & {DEPTH{write_strobe}};
        ld_c     = '0;
        rd_hit_c = read_strobe && (|sel_c);
        rd_mux_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ld_c[i] = SHADOW_EN ? (commit && pend_r[i]) : wr_c[i];
            if (sel_c[i]) begin
                rd_mux_c = q_r[i];
            end
        end
    end

    // Active registers, stage and pending flags, update pulses and read-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r      <= {DEPTH{RESET_VAL}};
            stage_r  <= {DEPTH{RESET_VAL}};
            pend_r   <= '0;
            upd_r    <= '0;
            rdata_r  <= '0;
            rvalid_r <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                // Commit takes the stage value from before this edge, and a
                // same-cycle write then refills the stage.
                if (ld_c[i]) begin
                    q_r[i] <= SHADOW_EN ? stage_r[i] : out_port;
                end
                if (SHADOW_EN && wr_c[i]) begin
                    stage_r[i] <= out_port;
                end
                pend_r[i] <= SHADOW_EN && (wr_c[i] || (pend_r[i] && !commit));
            end
            upd_r    <= ld_c;
            rdata_r  <= rd_hit_c ? rd_mux_c : '0;
            rvalid_r <= rd_hit_c;
        end
    end

    assign q       = q_r;
    assign upd     = upd_r;
    assign pending = pend_r;
    assign rdata   = rdata_r;
    assign rvalid  = rvalid_r;

endmodule

// File: tb/tb_io_reg_bank.sv
// Scoreboard bench for io_reg_bank. It runs one direct-load instance and one
// shadow-load instance.
module tb_io_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // direct instance (SHADOW=0, BASE=0x10)
    logic        reset_d = 1'b1, ws_d = 1'b0, rs_d = 1'b0, cm_d = 1'b0;
    logic [15:0] pid_d = '0;
    logic [7:0]  op_d = '0;
    logic [31:0] q_d;
    logic [3:0]  upd_d, pend_d;
    logic [7:0]  rdata_d;
    logic        rvalid_d;

    // shadow instance (SHADOW=1, BASE=0x20)
    logic        reset_s = 1'b1, ws_s = 1'b0, rs_s = 1'b0, cm_s = 1'b0;
    logic [15:0] pid_s = '0;
    logic [7:0]  op_s = '0;
    logic [31:0] q_s;
    logic [3:0]  upd_s, pend_s;
    logic [7:0]  rdata_s;
    logic        rvalid_s;

    io_reg_bank #(.WIDTH(8), .DEPTH(4), .AW(16), .BASE(32'h10), .SHADOW(0), .RESET_VAL(8'h00)) u_direct (
        .clk(clk), .reset(reset_d), .port_id(pid_d), .write_strobe(ws_d), .read_strobe(rs_d),
        .out_port(op_d), .commit(cm_d), .q(q_d), .upd(upd_d), .pending(pend_d),
        .rdata(rdata_d), .rvalid(rvalid_d));

    io_reg_bank #(.WIDTH(8), .DEPTH(4), .AW(16), .BASE(32'h20), .SHADOW(1), .RESET_VAL(8'h00)) u_shadow (
        .clk(clk), .reset(reset_s), .port_id(pid_s), .write_strobe(ws_s), .read_strobe(rs_s),
        .out_port(op_s), .commit(cm_s), .q(q_s), .upd(upd_s), .pending(pend_s),
        .rdata(rdata_s), .rvalid(rvalid_s));

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [3:0]  upd;
        logic [3:0]  pend;
        logic        rvalid;
        logic [7:0]  rdata;
    } exp_t;

    exp_t sb_d[$];
    exp_t sb_s[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input string n, input logic [31:0] q, input logic [3:0] u,
                                input logic [3:0] p, input logic rv, input logic [7:0] rd);
        exp_t e;
        e.name = n; e.q = q; e.upd = u; e.pend = p; e.rvalid = rv; e.rdata = rd;
        return e;
    endfunction

    function automatic void compare(input exp_t e, input logic [31:0] q, input logic [3:0] u,
                                    input logic [3:0] p, input logic rv, input logic [7:0] rd);
        checks++;
        if (q !== e.q || u !== e.upd || p !== e.pend || rv !== e.rvalid || rd !== e.rdata) begin
            errors++;
            $display("FAIL %s: got q=%h upd=%b pend=%b rvalid=%b rdata=%h, want q=%h upd=%b pend=%b rvalid=%b rdata=%h",
                     e.name, q, u, p, rv, rd, e.q, e.upd, e.pend, e.rvalid, e.rdata);
        end
    endfunction

    function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endfunction

    // Monitor for the direct instance: any output event must match the next expected entry.
    always @(negedge clk) begin
        if (rvalid_d === 1'b1 || (upd_d !== 4'b0000 && upd_d !== 4'bxxxx)) begin
            if (sb_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL direct_unexpected: got q=%h upd=%b rvalid=%b rdata=%h, want no event",
                         q_d, upd_d, rvalid_d, rdata_d);
            end else begin
                compare(sb_d.pop_front(), q_d, upd_d, pend_d, rvalid_d, rdata_d);
            end
        end
    end

    // Monitor for the shadow instance.
    always @(negedge clk) begin
        if (rvalid_s === 1'b1 || (upd_s !== 4'b0000 && upd_s !== 4'bxxxx)) begin
            if (sb_s.size() == 0) begin
                checks++; errors++;
                $display("FAIL shadow_unexpected: got q=%h upd=%b rvalid=%b rdata=%h, want no event",
                         q_s, upd_s, rvalid_s, rdata_s);
            end else begin
                compare(sb_s.pop_front(), q_s, upd_s, pend_s, rvalid_s, rdata_s);
            end
        end
    end

    // One processor cycle on the selected instance (sel=0 direct, 1 shadow).
    task automatic cyc(input bit sel, input logic w, input logic r, input logic c,
                       input logic [15:0] a, input logic [7:0] d);
        if (sel) begin ws_s = w; rs_s = r; cm_s = c; pid_s = a; op_s = d; end
        else     begin ws_d = w; rs_d = r; cm_d = c; pid_d = a; op_d = d; end
        @(posedge clk); #1;
        ws_d = 1'b0; rs_d = 1'b0; cm_d = 1'b0;
        ws_s = 1'b0; rs_s = 1'b0; cm_s = 1'b0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q_d", 64'(q_d), 64'h0);
        chk("reset_upd_d", 64'(upd_d), 64'h0);
        chk("reset_rd_d", 64'({rvalid_d, rdata_d}), 64'h0);
        chk("reset_q_s", 64'(q_s), 64'h0);
        chk("reset_pend_s", 64'(pend_s), 64'h0);
        reset_d = 1'b0; reset_s = 1'b0;
        @(posedge clk); #1;

        // ---------------- direct instance ----------------
        sb_d.push_back(mk("d_wr_A5", 32'h00A50000, 4'b0100, 4'b0000, 1'b0, 8'h00));
        cyc(0, 1, 0, 0, 16'h0012, 8'hA5);
        cyc(0, 1, 0, 0, 16'h000F, 8'h77);   // below window
        cyc(0, 1, 0, 0, 16'h0014, 8'h77);   // above window
        cyc(0, 0, 1, 0, 16'h0014, 8'h00);   // read above window: no rvalid
        chk("d_oow_q", 64'(q_d), 64'h00A50000);
        chk("d_oow_rd", 64'({rvalid_d, rdata_d}), 64'h0);
        chk("d_oow_pend", 64'(pend_d), 64'h0);
        sb_d.push_back(mk("d_wr_3C", 32'h00A5003C, 4'b0001, 4'b0000, 1'b0, 8'h00));
        cyc(0, 1, 0, 0, 16'h0010, 8'h3C);
        sb_d.push_back(mk("d_rd_3C", 32'h00A5003C, 4'b0000, 4'b0000, 1'b1, 8'h3C));
        cyc(0, 0, 1, 0, 16'h0010, 8'h00);
        sb_d.push_back(mk("d_rdwr_same", 32'h00A50055, 4'b0001, 4'b0000, 1'b1, 8'h3C));
        cyc(0, 1, 1, 0, 16'h0010, 8'h55);
        sb_d.push_back(mk("d_rewrite", 32'h00A50055, 4'b0001, 4'b0000, 1'b0, 8'h00));
        cyc(0, 1, 0, 0, 16'h0010, 8'h55);
        cyc(0, 0, 0, 1, 16'h0010, 8'h00);   // commit ignored
        chk("d_commit_ign", 64'({q_d, pend_d}), 64'({32'h00A50055, 4'b0000}));
        sb_d.push_back(mk("d_wr_top", 32'h9AA50055, 4'b1000, 4'b0000, 1'b0, 8'h00));
        cyc(0, 1, 0, 0, 16'h0013, 8'h9A);
        sb_d.push_back(mk("d_rd_top", 32'h9AA50055, 4'b0000, 4'b0000, 1'b1, 8'h9A));
        cyc(0, 0, 1, 0, 16'h0013, 8'h00);

        // ---------------- shadow instance ----------------
        cyc(1, 1, 0, 0, 16'h0020, 8'h01);
        cyc(1, 1, 0, 0, 16'h0021, 8'h96);
        chk("s_staged", 64'({q_s, pend_s}), 64'({32'h0, 4'b0011}));
        sb_s.push_back(mk("s_commit1", 32'h00009601, 4'b0011, 4'b0000, 1'b0, 8'h00));
        cyc(1, 0, 0, 1, 16'h0000, 8'h00);
        cyc(1, 1, 0, 0, 16'h0021, 8'h11);
        chk("s_pend1", 64'(pend_s), 64'h2);
        sb_s.push_back(mk("s_wr_commit", 32'h00001101, 4'b0010, 4'b0010, 1'b0, 8'h00));
        cyc(1, 1, 0, 1, 16'h0021, 8'h22);
        sb_s.push_back(mk("s_commit2", 32'h00002201, 4'b0010, 4'b0000, 1'b0, 8'h00));
        cyc(1, 0, 0, 1, 16'h0000, 8'h00);
        cyc(1, 0, 0, 1, 16'h0000, 8'h00);   // nothing pending
        chk("s_empty_commit", 64'({q_s, pend_s}), 64'({32'h00002201, 4'b0000}));
        cyc(1, 1, 0, 0, 16'h0020, 8'h44);
        sb_s.push_back(mk("s_rd_active", 32'h00002201, 4'b0000, 4'b0001, 1'b1, 8'h01));
        cyc(1, 0, 1, 0, 16'h0020, 8'h00);
        sb_s.push_back(mk("s_commit3", 32'h00002244, 4'b0001, 4'b0000, 1'b0, 8'h00));
        cyc(1, 0, 0, 1, 16'h0000, 8'h00);

        // Apply reset asynchronously while data is staged.
        cyc(1, 1, 0, 0, 16'h0022, 8'hFF);
        chk("s_pend_ff", 64'(pend_s), 64'h4);
        #2 reset_s = 1'b1;
        #1;
        chk("s_async_rst", 64'({q_s, pend_s}), 64'h0);
        #3 reset_s = 1'b0;
        @(posedge clk); #1;
        cyc(1, 0, 0, 1, 16'h0000, 8'h00);
        @(posedge clk); #1;
        chk("s_post_rst_commit", 64'({q_s, pend_s, upd_s}), 64'h0);

        // Drain: every expected event must have been seen.
        repeat (3) @(posedge clk);
        #1;
        while (sb_d.size() != 0) begin
            exp_t e = sb_d.pop_front();
            checks++; errors++;
            $display("FAIL %s: got no event want q=%h upd=%b", e.name, e.q, e.upd);
        end
        while (sb_s.size() != 0) begin
            exp_t e = sb_s.pop_front();
            checks++; errors++;
            $display("FAIL %s: got no event want q=%h upd=%b", e.name, e.q, e.upd);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_reg_bank.md
Name: io_reg_bank

Overview:
- Parametrised, address-decoded bank of output registers loaded from the Tramelblaze OUT_PORT on write_strobe; this replaces individual 8-bit load registers.
- Optional shadow mode: writes are staged and then applied atomically on a commit strobe, so multi-register settings (baud divisors, control words) update together.
- Registered read-back of the active values to the processor IN_PORT mux.
- Per-register update pulses let downstream logic (UART tx/baud) react to new settings.

Parameters:
- WIDTH, 8, data width of each register and of out_port/rdata.
- DEPTH, 4, number of registers (1..16).
- AW, 16, width of port_id.
- BASE, 0, port_id of register 0. Registers occupy BASE..BASE+DEPTH-1. BASE+DEPTH must be <= 2^AW; otherwise elaboration error.
- SHADOW, 0, 0 = direct load, 1 = staged load applied on commit.
- RESET_VAL, 0, reset value of every active and stage register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- port_id  input  AW  processor port address.
- write_strobe  input  1  one-cycle write qualifier.
- read_strobe  input  1  one-cycle read qualifier.
- out_port  input  WIDTH  processor write data.
- commit  input  1  one-cycle apply strobe; ignored when SHADOW=0.
- q  output  DEPTH*WIDTH  active register values; register i at bits [i*WIDTH +: WIDTH].
- upd  output  DEPTH  one-cycle pulse per register whose active value was loaded.
- pending  output  DEPTH  stage holds unapplied data (SHADOW=1); constant 0 when SHADOW=0.
- rdata  output  WIDTH  registered read-back data.
- rvalid  output  1  rdata valid pulse.

Behaviour:
- Reset (async, any time, including mid-stage): q and stage = RESET_VAL; pending = 0, upd = 0, rdata = 0, rvalid = 0. Staged data is discarded.
- Decode: hit = (port_id >= BASE) && (port_id <= BASE+DEPTH-1); idx = port_id - BASE. Compare using AW+1-bit arithmetic so there is no wrap-around. Addresses outside the window are ignored with no side effects.
- SHADOW=0:
  - write_strobe && hit → q[idx] <= out_port at the next rising edge.
  - upd[idx] = 1 for exactly that following cycle, aligned with the new q.
  - A rewrite of the same value still pulses upd.
  - commit is ignored.
- SHADOW=1, write:
  - write_strobe && hit → stage[idx] <= out_port; pending[idx] <= 1.
  - q is unchanged.
  - Rewriting a pending register overwrites the stage; last write wins.
- SHADOW=1, commit:
  - For every i with pending[i]=1: q[i] <= stage[i], pending[i] <= 0, upd[i] pulses the next cycle.
  - All loads land on the same edge (atomic).
  - commit with pending=0 does nothing; upd stays 0.
- SHADOW=1, write and commit in the same cycle:
  - Commit uses the stage contents from before this edge.
  - The write then lands in stage and pending[idx] is 1 after the edge.
  - If idx was already pending: q[idx] gets the old stage value, stage[idx] gets the new data, pending[idx] stays 1.
- Read:
  - read_strobe && hit → next cycle rdata = q[idx] (active value, never stage) and rvalid = 1.
  - Otherwise rvalid = 0 and rdata = 0.
  - Latency is 1 cycle.
  - Read and write to the same idx in one cycle returns the pre-write value.
- write_strobe and read_strobe high together are both serviced independently.
- upd is registered and never asserted combinationally from inputs.

Test Plan:
- SHADOW=0, BASE=16'h0010, DEPTH=4: reset, write 8'hA5 to port 16'h0012 → q[23:16]=A5 one cycle later, upd=4'b0100 for one cycle, other bytes 00.
- Out-of-window: write 8'h77 to ports 16'h000F and 16'h0014 → q, upd, pending unchanged; read of 16'h0014 → rvalid=0, rdata=0.
- SHADOW=1: write 8'h01 to reg0 and 8'h96 to reg1 → pending=4'b0011, q unchanged. Pulse commit → q[7:0]=01 and q[15:8]=96 on the same edge, upd=4'b0011, pending=0.
- SHADOW=1: reg1 pending with 8'h11; same cycle write 8'h22 to reg1 and commit → q[15:8]=11, pending[1]=1. Second commit → q[15:8]=22, pending[1]=0.
- Read-back: after q[7:0]=8'h3C, read port BASE → next cycle rdata=3C, rvalid=1. Simultaneous write 8'h55 to reg0 and read reg0 → rdata=3C, then q[7:0]=55.
- Reset mid-operation: stage reg2 with 8'hFF (pending[2]=1), assert reset asynchronously between edges → q=RESET_VAL and pending=0 immediately. A later commit loads nothing.
